// File: rtl/setpoint_cmd_arbiter.sv
// Debounces front-panel up/down buttons with hold-to-repeat and arbitrates them against a
// host valid/ready port, issuing spaced single-cycle inc/dec strobes to the setpoint counter.
module setpoint_cmd_arbiter #(
  parameter int CNT_W        = 20,
  parameter int DEB_CYCLES   = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int GAP_CYCLES   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic host_valid,
  input  logic host_dir,
  output logic host_ready,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic src_host,
  output logic busy
);

  // The repeat counter widens itself when CNT_W cannot reach the repeat delay.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = ($clog2(RPT_MAX + 1) > CNT_W) ? $clog2(RPT_MAX + 1) : CNT_W;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_REPEAT = 2'd3;

  logic [1:0]       up_sync, dn_sync;
  logic [1:0]       raw_s, deb_lvl, flip, rise;
  logic [CNT_W-1:0] deb_cnt [2];
  logic [1:0]       state;
  logic             dir;
  logic [RPT_W-1:0] rpt_cnt;
  logic             held, both_hi, abort, post;
  logic             pend_vld, pend_dir;
  logic [CNT_W-1:0] gap;
  logic             run, can_issue, btn_fire, host_fire;

  assign raw_s = {dn_sync[1], up_sync[1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_dn};
    end
  end

  // Bit 0 is the up button, bit 1 the down button throughout.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flip[i] = (raw_s[i] != deb_lvl[i]) && (deb_cnt[i] == DEB_LAST);
    end
    rise = flip & raw_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_lvl <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_s[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (flip[i]) begin
          deb_lvl[i] <= raw_s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign both_hi = &deb_lvl;

  always_comb begin
    held  = dir ? deb_lvl[0] : deb_lvl[1];
    abort = !enable || both_hi || (state != S_IDLE && !held);
    post  = 1'b0;
    case (state)
      S_FIRST:  post = 1'b1;
      S_HOLD:   post = (rpt_cnt == DLY_LAST);
      S_REPEAT: post = (rpt_cnt == RATE_LAST);
      default:  post = 1'b0;
    endcase
    if (abort) post = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      dir     <= 1'b0;
      rpt_cnt <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      rpt_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A rise on both buttons at once is not a valid press.
          if (rise == 2'b01 || rise == 2'b10) begin
            state   <= S_FIRST;
            dir     <= rise[0];
            rpt_cnt <= '0;
          end
        end
        S_FIRST: begin
          state   <= S_HOLD;
          rpt_cnt <= '0;
        end
        S_HOLD: begin
          if (rpt_cnt == DLY_LAST) begin
            state   <= S_REPEAT;
            rpt_cnt <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        default: begin
          if (rpt_cnt == RATE_LAST) rpt_cnt <= '0;
          else                      rpt_cnt <= rpt_cnt + 1'b1;
        end
      endcase
    end
  end

  // run keeps host_ready low while reset is asserted and for the first cycle after it.
  assign can_issue  = run && enable && (gap == '0);
  assign btn_fire   = can_issue && pend_vld && !both_hi;
  assign host_ready = can_issue && !pend_vld;
  assign host_fire  = host_valid && host_ready;
  assign busy       = (gap != '0) || pend_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run       <= 1'b0;
      pend_vld  <= 1'b0;
      pend_dir  <= 1'b0;
      gap       <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      src_host  <= 1'b0;
    end else begin
      run <= 1'b1;
      // A fresh button request overwrites one that has not been issued yet.
      if (!enable || both_hi) begin
        pend_vld <= 1'b0;
      end else if (post) begin
        pend_vld <= 1'b1;
        pend_dir <= dir;
      end else if (btn_fire) begin
        pend_vld <= 1'b0;
      end
      inc_pulse <= (btn_fire && pend_dir) || (host_fire && host_dir);
      dec_pulse <= (btn_fire && !pend_dir) || (host_fire && !host_dir);
      if (btn_fire || host_fire) begin
        src_host <= host_fire;
        gap      <= GAP_LOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_setpoint_cmd_arbiter.sv
// Directed bench for setpoint_cmd_arbiter: a per-cycle vector table for the host path plus
// hand-written button, priority, both-button, reset and enable sequences.
module tb_setpoint_cmd_arbiter;

  logic clk = 1'b0;
  logic reset_n, enable, btn_up, btn_dn, host_valid, host_dir;
  logic host_ready, inc_pulse, dec_pulse, src_host, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int inc_q[$], dec_q[$], inc_src[$], dec_src[$];
  int both_cnt = 0;

  typedef struct packed {
    logic en, vld, dir;
    logic rdy, inc, dec, bsy, src;
  } vec_t;
  vec_t tbl[23];

  setpoint_cmd_arbiter #(
    .CNT_W(20), .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .btn_up(btn_up), .btn_dn(btn_dn),
    .host_valid(host_valid), .host_dir(host_dir), .host_ready(host_ready),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .src_host(src_host), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobes are logged by the edge count at which they became visible.
  always @(negedge clk) begin
    if (inc_pulse) begin inc_q.push_back(cyc); inc_src.push_back(int'(src_host)); end
    if (dec_pulse) begin dec_q.push_back(cyc); dec_src.push_back(int'(src_host)); end
    if (inc_pulse && dec_pulse) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int c0, c1, ib, db;

    tbl[0]  = 8'b110_10000; tbl[1]  = 8'b110_00111; tbl[2]  = 8'b110_00011;
    tbl[3]  = 8'b110_10001; tbl[4]  = 8'b110_00111; tbl[5]  = 8'b110_00011;
    tbl[6]  = 8'b110_10001; tbl[7]  = 8'b110_00111; tbl[8]  = 8'b110_00011;
    tbl[9]  = 8'b110_10001; tbl[10] = 8'b100_00111; tbl[11] = 8'b100_00011;
    tbl[12] = 8'b100_10001; tbl[13] = 8'b011_00001; tbl[14] = 8'b011_00001;
    tbl[15] = 8'b111_10001; tbl[16] = 8'b101_01011; tbl[17] = 8'b100_00011;
    tbl[18] = 8'b100_10001; tbl[19] = 8'b110_10001; tbl[20] = 8'b010_00111;
    tbl[21] = 8'b010_00011; tbl[22] = 8'b100_10001;

    // Reset: every output low even with a host command waiting.
    reset_n = 1'b0; enable = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
    host_valid = 1'b1; host_dir = 1'b1;
    repeat (3) tick();
    chk("rst_ready", host_ready, 0);
    chk("rst_inc", inc_pulse, 0);
    chk("rst_dec", dec_pulse, 0);
    chk("rst_src", src_host, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1; host_valid = 1'b0;
    repeat (2) tick();

    // Host path: strobe every 3 cycles, enable gating, gap runs while disabled.
    for (int i = 0; i < 23; i++) begin
      enable = tbl[i].en; host_valid = tbl[i].vld; host_dir = tbl[i].dir;
      #3;
      chk($sformatf("tbl%0d_ready", i), host_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_inc", i), inc_pulse, tbl[i].inc);
      chk($sformatf("tbl%0d_dec", i), dec_pulse, tbl[i].dec);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_src", i), src_host, tbl[i].src);
      tick();
    end
    enable = 1'b1; host_valid = 1'b0;

    // Glitchy short presses never pass the debouncer.
    ib = inc_q.size(); db = dec_q.size();
    foreach (tbl[i]) begin end
    btn_up = 1'b1; tick(); tick(); btn_up = 1'b0; tick();
    btn_up = 1'b1; tick(); tick(); btn_up = 1'b0; tick();
    btn_up = 1'b1; tick(); btn_up = 1'b0;
    repeat (10) tick();
    chk("glitch_deb", dut.deb_lvl, 0);
    chk("glitch_strobes", inc_q.size() - ib + dec_q.size() - db, 0);
    chk("glitch_busy", busy, 0);

    // Held up button: first strobe, then repeats at +20 and +28.
    ib = inc_q.size(); db = dec_q.size();
    c0 = cyc;
    btn_up = 1'b1;
    repeat (32) tick();
    btn_up = 1'b0;
    repeat (40) tick();
    chk("hold_count", inc_q.size() - ib, 3);
    if (inc_q.size() - ib == 3) begin
      chk("hold_first", inc_q[ib], c0 + 8);
      chk("hold_rep1", inc_q[ib+1], c0 + 28);
      chk("hold_rep2", inc_q[ib+2], c0 + 36);
      chk("hold_src", inc_src[ib] + inc_src[ib+1] + inc_src[ib+2], 0);
    end
    chk("hold_no_dec", dec_q.size() - db, 0);

    // Pending button beats a host command presented in the same cycle.
    ib = inc_q.size(); db = dec_q.size();
    c0 = cyc;
    btn_dn = 1'b1;
    repeat (7) tick();
    chk("prio_busy", busy, 1);
    host_valid = 1'b1; host_dir = 1'b1;
    #1 chk("prio_ready_blocked", host_ready, 0);
    tick();
    chk("prio_dec", dec_pulse, 1);
    tick(); tick();
    chk("prio_ready_after_gap", host_ready, 1);
    tick();
    chk("prio_inc", inc_pulse, 1);
    host_valid = 1'b0;
    tick();
    btn_dn = 1'b0;
    repeat (30) tick();
    chk("prio_dec_count", dec_q.size() - db, 1);
    chk("prio_inc_count", inc_q.size() - ib, 1);
    if (dec_q.size() - db == 1 && inc_q.size() - ib == 1) begin
      chk("prio_dec_time", dec_q[db], c0 + 8);
      chk("prio_inc_time", inc_q[ib], c0 + 11);
      chk("prio_dec_src", dec_src[db], 0);
      chk("prio_inc_src", inc_src[ib], 1);
    end

    // Both buttons together: nothing at all.
    ib = inc_q.size(); db = dec_q.size();
    btn_up = 1'b1; btn_dn = 1'b1;
    repeat (30) tick();
    chk("both_busy", busy, 0);
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (20) tick();
    chk("both_strobes", inc_q.size() - ib + dec_q.size() - db, 0);

    // Reset in the middle of a gap; a waiting host command survives it.
    host_valid = 1'b1; host_dir = 1'b1;
    tick();
    chk("mid_inc_before_rst", inc_pulse, 1);
    reset_n = 1'b0; host_dir = 1'b0;
    #1;
    chk("mid_rst_inc", inc_pulse, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_src", src_host, 0);
    chk("mid_rst_ready", host_ready, 0);
    repeat (3) tick();
    chk("mid_rst_ready_held", host_ready, 0);
    chk("mid_rst_dec_held", dec_pulse, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", host_ready, 1);
    tick();
    chk("post_rst_dec", dec_pulse, 1);
    host_valid = 1'b0;
    repeat (5) tick();

    // Enable low with a request pending, then re-enable while still held.
    ib = inc_q.size(); db = dec_q.size();
    btn_up = 1'b1;
    repeat (7) tick();
    chk("en_pending", busy, 1);
    enable = 1'b0;
    #1 chk("en_low_ready", host_ready, 0);
    tick();
    chk("en_low_busy", busy, 0);
    repeat (5) tick();
    enable = 1'b1;
    repeat (40) tick();
    chk("en_held_no_strobe", inc_q.size() - ib + dec_q.size() - db, 0);
    btn_up = 1'b0;
    repeat (10) tick();
    c1 = cyc;
    btn_up = 1'b1;
    repeat (10) tick();
    btn_up = 1'b0;
    repeat (30) tick();
    chk("repress_count", inc_q.size() - ib, 1);
    if (inc_q.size() - ib == 1) chk("repress_time", inc_q[ib], c1 + 8);

    chk("never_both_pulses", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
